// File: rtl/mill_rx_pkg.sv
// rtl/mill_rx_pkg.sv - shared types and defaults for the modified-Miller receive controller
package mill_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_SOF,
        ST_RX,
        ST_EOF
    } rx_state_e;

    localparam int ETU_CLKS_DEF     = 8;
    localparam int SAMPLE_OFS_DEF   = 1;
    localparam int IDLE_ETUS_DEF    = 2;
    localparam int SHORT_FRAME_BITS = 7;

endpackage

// File: rtl/mill_etu_timer.sv
// rtl/mill_etu_timer.sv - ETU counter, previous-ETU sample strobe and idle-ETU counter
module mill_etu_timer
    import mill_rx_pkg::*;
#(
    parameter int ETU_CLKS   = ETU_CLKS_DEF,
    parameter int SAMPLE_OFS = SAMPLE_OFS_DEF,
    parameter int IDLE_ETUS  = IDLE_ETUS_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start_i,
    input  logic run_i,
    input  logic line_i,
    output logic sample_stb_o,
    output logic prev_idle_o,
    output logic idle_done_o
);

    localparam int CW = (ETU_CLKS > 1) ? $clog2(ETU_CLKS) : 1;
    localparam int IW = $clog2(IDLE_ETUS + 1);

    logic [CW-1:0] cnt_q;
    logic [IW-1:0] idle_cnt_q;
    logic          pause_seen_q;
    logic          first_q;
    logic          prev_idle_q;
    logic          etu_end;
    logic          etu_had_pause;

    assign etu_end       = run_i && (cnt_q == CW'(ETU_CLKS - 1));
    assign etu_had_pause = pause_seen_q || !line_i;

    // ETU 0 is opened by the SOF pause itself, so it starts out as non-idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            idle_cnt_q   <= '0;
            pause_seen_q <= 1'b0;
            first_q      <= 1'b0;
            prev_idle_q  <= 1'b0;
        end else if (start_i) begin
            cnt_q        <= '0;
            idle_cnt_q   <= '0;
            pause_seen_q <= 1'b1;
            first_q      <= 1'b1;
            prev_idle_q  <= 1'b0;
        end else if (run_i) begin
            if (etu_end) begin
                cnt_q        <= '0;
                pause_seen_q <= 1'b0;
                first_q      <= 1'b0;
                prev_idle_q  <= !etu_had_pause;
                if (etu_had_pause) begin
                    idle_cnt_q <= '0;
                end else if (idle_cnt_q != IW'(IDLE_ETUS)) begin
                    idle_cnt_q <= idle_cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= cnt_q + 1'b1;
                if (!line_i) begin
                    pause_seen_q <= 1'b1;
                end
            end
        end
    end

    assign sample_stb_o = run_i && !first_q && (cnt_q == CW'(SAMPLE_OFS));
    assign prev_idle_o  = prev_idle_q;
    assign idle_done_o  = etu_end && !etu_had_pause && (idle_cnt_q == IW'(IDLE_ETUS - 1));

endmodule

// File: rtl/mill_modif_rx_ctrl.sv
// rtl/mill_modif_rx_ctrl.sv - ISO14443A modified-Miller receive framing controller
module mill_modif_rx_ctrl
    import mill_rx_pkg::*;
#(
    parameter int ETU_CLKS   = ETU_CLKS_DEF,
    parameter int SAMPLE_OFS = SAMPLE_OFS_DEF,
    parameter int IDLE_ETUS  = IDLE_ETUS_DEF
) (
    input  logic       clk,
    input  logic       in_enable,
    input  logic       rx_arm,
    input  logic       line_in,
    input  logic       dec_data,
    output logic       dec_enable,
    output logic [7:0] byte_data,
    output logic       byte_valid,
    input  logic       byte_ready,
    output logic       busy,
    output logic       frame_done,
    output logic       short_frame,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun
);

    rx_state_e  state_q, state_d;
    logic       in_rx, start, sample_stb, prev_idle, idle_done;
    logic       sof_err, data_stb, byte_done, short_done, push, accept;
    logic [7:0] push_val;
    logic       sof_pend_q, got_byte_q, par_q;
    logic [3:0] bit_cnt_q;
    logic [7:0] shreg_q, byte_data_q;
    logic       byte_valid_q, short_q, perr_q, ferr_q, ovr_q;

    assign in_rx = (state_q == ST_RX);
    assign start = (state_q == ST_WAIT_SOF) && !line_in;

    mill_etu_timer #(
        .ETU_CLKS   (ETU_CLKS),
        .SAMPLE_OFS (SAMPLE_OFS),
        .IDLE_ETUS  (IDLE_ETUS)
    ) u_etu_timer (
        .clk          (clk),
        .rst_n        (in_enable),
        .start_i      (start),
        .run_i        (in_rx),
        .line_i       (line_in),
        .sample_stb_o (sample_stb),
        .prev_idle_o  (prev_idle),
        .idle_done_o  (idle_done)
    );

    // End-of-frame wins over every sample decision in the same cycle.
    assign sof_err    = sample_stb && sof_pend_q && dec_data && !idle_done;
    assign data_stb   = sample_stb && !sof_pend_q && !prev_idle && !idle_done;
    assign byte_done  = data_stb && (bit_cnt_q == 4'd8);
    assign short_done = idle_done && !got_byte_q && (bit_cnt_q == 4'(SHORT_FRAME_BITS));
    assign push       = byte_done || short_done;
    assign accept     = byte_valid_q && byte_ready;
    assign push_val   = byte_done ? shreg_q : {1'b0, shreg_q[6:0]};

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:     if (rx_arm) state_d = ST_WAIT_SOF;
            ST_WAIT_SOF: if (!line_in) state_d = ST_RX;
            ST_RX: begin
                if (idle_done) begin
                    state_d = ST_EOF;
                end else if (sof_err) begin
                    state_d = ST_WAIT_SOF;
                end
            end
            ST_EOF:      state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge in_enable) begin
        if (!in_enable) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge in_enable) begin
        if (!in_enable) begin
            sof_pend_q   <= 1'b0;
            got_byte_q   <= 1'b0;
            par_q        <= 1'b0;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            byte_data_q  <= '0;
            byte_valid_q <= 1'b0;
            short_q      <= 1'b0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            ovr_q        <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && rx_arm) begin
                short_q <= 1'b0;
                perr_q  <= 1'b0;
                ferr_q  <= 1'b0;
                ovr_q   <= 1'b0;
            end
            if (start) begin
                sof_pend_q <= 1'b1;
                got_byte_q <= 1'b0;
                par_q      <= 1'b0;
                bit_cnt_q  <= '0;
                shreg_q    <= '0;
            end
            if (sample_stb && sof_pend_q && !idle_done) begin
                sof_pend_q <= 1'b0;
            end
            if (sof_err) begin
                ferr_q <= 1'b1;
            end
            if (data_stb) begin
                if (bit_cnt_q == 4'd8) begin
                    bit_cnt_q  <= '0;
                    par_q      <= 1'b0;
                    got_byte_q <= 1'b1;
                    if (!(par_q ^ dec_data)) begin
                        perr_q <= 1'b1;
                    end
                end else begin
                    shreg_q[bit_cnt_q[2:0]] <= dec_data;
                    par_q                   <= par_q ^ dec_data;
                    bit_cnt_q               <= bit_cnt_q + 1'b1;
                end
            end
            if (idle_done) begin
                if (short_done) begin
                    short_q <= 1'b1;
                end else if (!(bit_cnt_q == 4'd0 && got_byte_q)) begin
                    ferr_q <= 1'b1;
                end
            end
            // A completed byte may replace the pending one only when it leaves this cycle.
            if (push && (!byte_valid_q || byte_ready)) begin
                byte_data_q  <= push_val;
                byte_valid_q <= 1'b1;
            end else begin
                if (push) begin
                    ovr_q <= 1'b1;
                end
                if (accept) begin
                    byte_valid_q <= 1'b0;
                end
            end
        end
    end

    assign dec_enable  = in_rx || start;
    assign busy        = (state_q != ST_IDLE);
    assign frame_done  = (state_q == ST_EOF);
    assign byte_data   = byte_data_q;
    assign byte_valid  = byte_valid_q;
    assign short_frame = short_q;
    assign parity_err  = perr_q;
    assign frame_err   = ferr_q;
    assign overrun     = ovr_q;

endmodule
